// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package mmio_pkg;

    localparam logic [1:0] UART_TXDATA_OFF = 2'd0;
    localparam logic [1:0] UART_STATUS_OFF = 2'd1;
    localparam logic [1:0] UART_CLKDIV_OFF = 2'd2;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_FULL_BIT    = 1;
    localparam int STATUS_EMPTY_BIT   = 2;
    localparam int STATUS_OVERRUN_BIT = 3;
    localparam int STATUS_PARITY_BIT  = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with read/write pointers, an occupancy count and a
// combinational head output.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is discarded even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus with a TX FIFO.
// Define MMIO_UART_TX_PARITY_EN to add an even-parity bit to every frame.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter int               FIFO_DEPTH  = 4,
    parameter logic [15:0]      DEFAULT_DIV = 16'd867
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] addr_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       byteen,
    output logic [WIDTH-1:0] data_out,
    output logic             tx,
    output logic             irq
);

    uart_tx_state_t state, state_next;

    logic             sel;
    logic [1:0]       offset;
    logic             wr_en;
    logic             push_req;
    logic             ovr_clr;
    logic [15:0]      clkdiv;
    logic             overrun;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_d;
    logic [2:0]       bit_idx;
    logic [15:0]      bit_cnt;
    logic             bit_done;
    logic             tx_d;
    logic [WIDTH-1:0] status_word;
    logic [WIDTH-1:0] rd_data;
    logic             unused_bits;
`ifdef MMIO_UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign sel         = (addr_in[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
    assign offset      = addr_in[3:2];
    assign wr_en       = mem_write && sel;
    assign push_req    = wr_en && (offset == UART_TXDATA_OFF) && byteen[0];
    assign ovr_clr     = wr_en && (offset == UART_STATUS_OFF) && byteen[0]
                         && data_in[STATUS_OVERRUN_BIT];
    assign bit_done    = (bit_cnt == '0);
    assign irq         = fifo_empty && (state == IDLE);
    assign unused_bits = ^{data_in[WIDTH-1:16], addr_in[1:0], byteen[3:2]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (data_in[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv  <= DEFAULT_DIV;
            overrun <= 1'b0;
        end else begin
            if (push_req && fifo_full) overrun <= 1'b1;
            else if (ovr_clr)          overrun <= 1'b0;
            if (wr_en && (offset == UART_CLKDIV_OFF)) begin
                if (byteen[0]) clkdiv[7:0]  <= data_in[7:0];
                if (byteen[1]) clkdiv[15:8] <= data_in[15:8];
            end
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_BUSY_BIT]    = (state != IDLE);
        status_word[STATUS_FULL_BIT]    = fifo_full;
        status_word[STATUS_EMPTY_BIT]   = fifo_empty;
        status_word[STATUS_OVERRUN_BIT] = overrun;
`ifdef MMIO_UART_TX_PARITY_EN
        status_word[STATUS_PARITY_BIT]  = 1'b1;
`endif
        rd_data = '0;
        case (offset)
            UART_STATUS_OFF: rd_data = status_word;
            UART_CLKDIV_OFF: rd_data[15:0] = clkdiv;
            default:         rd_data = '0;
        endcase
        data_out = (mem_read && sel) ? rd_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = START;
                    fifo_pop   = 1'b1;
                end
            end
            START: if (bit_done) state_next = DATA;
            DATA: begin
                if (bit_done && (bit_idx == 3'd7)) begin
`ifdef MMIO_UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: if (bit_done) state_next = STOP;
`endif
            // Chain straight into the next start bit so queued bytes leave with no idle gap.
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        state_next = START;
                        fifo_pop   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx is registered from the upcoming state, so the line changes on the same edge as the FSM.
    always_comb begin
        shift_d = shift_reg;
        if (fifo_pop)                     shift_d = fifo_dout;
        else if (state == DATA && bit_done) shift_d = shift_reg >> 1;
        tx_d = 1'b1;
        case (state_next)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[0];
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: tx_d = parity_bit;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx        <= 1'b1;
            shift_reg <= '0;
            bit_idx   <= '0;
            bit_cnt   <= '0;
        end else begin
            tx        <= tx_d;
            shift_reg <= shift_d;
            if (fifo_pop) begin
                bit_cnt <= clkdiv;
                bit_idx <= '0;
            end else if (state != IDLE) begin
                if (bit_done) begin
                    bit_cnt <= clkdiv;
                    if (state == DATA) bit_idx <= bit_idx + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt - 1'b1;
                end
            end
        end
    end

`ifdef MMIO_UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        parity_bit <= 1'b0;
        else if (fifo_pop) parity_bit <= ^fifo_dout;
    end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: register table, directed frame sequences and
// randomized bursts checked against a bit-timing model of the serial line.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] A_TX = BASE;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_CD = BASE + 32'h8;
    localparam logic [31:0] A_RS = BASE + 32'hC;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          FL   = 11;
    localparam logic [31:0] FEAT = 32'h10;
`else
    localparam int          FL   = 10;
    localparam logic [31:0] FEAT = 32'h0;
`endif

    typedef struct {
        string       name;
        bit          do_wr;
        bit          rd_wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [3:0]  byteen;
    logic [31:0] data_out;
    logic        tx;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] exp_q[$];
    vec_t vecs[12];

    mmio_uart_tx #(
        .WIDTH       (32),
        .BASE_ADDR   (32'h1000_0000),
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (16'd867)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .byteen    (byteen),
        .data_out  (data_out),
        .tx        (tx),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             input bit rd, output int wcyc);
        @(negedge clk);
        addr_in   = a;
        data_in   = d;
        byteen    = be;
        mem_write = 1'b1;
        mem_read  = rd;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        wcyc      = cyc;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_in  = a;
        mem_read = 1'b1;
        #1;
        d        = data_out;
        mem_read = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int          w;
        logic [31:0] rd;
        if (v.do_wr) bus_write(v.waddr, v.wdata, v.be, v.rd_wr, w);
        bus_read(v.raddr, rd);
        checkOutput(v.name, rd, v.exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
`ifdef MMIO_UART_TX_PARITY_EN
        if (pos == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Frames for exp_q go out back to back starting the cycle after the pop edge w+1.
    task automatic check_stream(input int w, input int d, input string tag);
        int          len;
        int          t;
        int          bitn;
        logic        e_tx;
        logic        e_busy;
        logic        e_irq;
        logic [31:0] st;
        len = exp_q.size() * FL * (d + 1);
        do begin
            @(negedge clk);
            t = cyc - (w + 1);
            if (t < 0) begin
                e_tx = 1'b1; e_busy = 1'b0; e_irq = 1'b0;
            end else if (t < len) begin
                bitn   = t / (d + 1);
                e_tx   = frame_bit(exp_q[bitn / FL], bitn % FL);
                e_busy = 1'b1;
                e_irq  = 1'b0;
            end else begin
                e_tx = 1'b1; e_busy = 1'b0; e_irq = 1'b1;
            end
            addr_in  = A_ST;
            mem_read = 1'b1;
            #1;
            st       = data_out;
            mem_read = 1'b0;
            checkOutput({tag, " tx"}, {31'b0, tx}, {31'b0, e_tx});
            checkOutput({tag, " busy"}, {31'b0, st[0]}, {31'b0, e_busy});
            checkOutput({tag, " irq"}, {31'b0, irq}, {31'b0, e_irq});
        end while (t < len + 2);
    endtask

    initial begin
        int          w;
        int          w0;
        int          d;
        int          k;
        logic [31:0] rd;
        logic [31:0] rv;

        rst_n = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        addr_in = '0; data_in = '0; byteen = '0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset tx", {31'b0, tx}, 32'h1);
        checkOutput("reset irq", {31'b0, irq}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{"status after reset", 0, 0, 0, 0, 4'h0, A_ST, 32'h4 | FEAT};
        vecs[1]  = '{"clkdiv after reset", 0, 0, 0, 0, 4'h0, A_CD, 32'd867};
        vecs[2]  = '{"txdata reads 0", 0, 0, 0, 0, 4'h0, A_TX, 32'h0};
        vecs[3]  = '{"reserved reads 0", 0, 0, 0, 0, 4'h0, A_RS, 32'h0};
        vecs[4]  = '{"outside window", 0, 0, 0, 0, 4'h0, BASE + 32'h20, 32'h0};
        vecs[5]  = '{"dmem space", 0, 0, 0, 0, 4'h0, 32'h0000_0104, 32'h0};
        vecs[6]  = '{"clkdiv byte0", 1, 0, A_CD, 32'hABCD_1234, 4'b0001, A_CD, 32'h0334};
        vecs[7]  = '{"clkdiv byte1", 1, 0, A_CD, 32'hFFFF_56FF, 4'b0010, A_CD, 32'h5634};
        vecs[8]  = '{"clkdiv word", 1, 0, A_CD, 32'h1234_5678, 4'b1111, A_CD, 32'h5678};
        vecs[9]  = '{"reserved write", 1, 0, A_RS, 32'hFFFF_FFFF, 4'b1111, A_RS, 32'h0};
        vecs[10] = '{"txdata be0010 no push", 1, 0, A_TX, 32'h0000_5555, 4'b0010, A_ST, 32'h4 | FEAT};
        vecs[11] = '{"write with read high", 1, 1, A_CD, 32'h0000_0003, 4'b0011, A_CD, 32'h3};
        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        bus_write(A_TX, 32'hA5, 4'b1111, 0, w);
        exp_q = '{8'hA5};
        check_stream(w, 3, "frame a5");

        bus_write(A_CD, 32'h0, 4'b0011, 0, w);
        bus_write(A_TX, 32'h55, 4'b0001, 0, w0);
        bus_write(A_TX, 32'h0F, 4'b0001, 0, w);
        exp_q = '{8'h55, 8'h0F};
        check_stream(w0, 0, "back to back");

        bus_write(A_CD, 32'h1, 4'b0011, 0, w);
        bus_write(A_TX, 32'h07, 4'b0001, 0, w0);
        exp_q = '{8'h07};
        check_stream(w0, 1, "frame 07");

        bus_write(A_CD, 32'd100, 4'b0011, 0, w);
        bus_write(A_TX, 32'h00, 4'b0001, 0, w0);
        bus_write(A_TX, 32'h11, 4'b0001, 0, w);
        bus_write(A_TX, 32'h22, 4'b0001, 0, w);
        bus_write(A_TX, 32'h33, 4'b0001, 0, w);
        bus_write(A_TX, 32'h44, 4'b0001, 0, w);
        bus_write(A_TX, 32'h66, 4'b0001, 0, w);
        bus_read(A_ST, rd);
        checkOutput("overflow status", rd, 32'hB | FEAT);
        bus_write(A_ST, 32'h8, 4'b0001, 0, w);
        bus_read(A_ST, rd);
        checkOutput("overrun cleared", rd, 32'h3 | FEAT);

        // Land inside data bit 2 of the all-zero first byte, then yank reset.
        while (cyc - (w0 + 1) < 350) @(negedge clk);
        checkOutput("mid data tx", {31'b0, tx}, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset tx", {31'b0, tx}, 32'h1);
        checkOutput("async reset irq", {31'b0, irq}, 32'h1);
        bus_read(A_ST, rd);
        checkOutput("reset status", rd, 32'h4 | FEAT);
        bus_read(A_CD, rd);
        checkOutput("reset clkdiv", rd, 32'd867);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("fifo discarded tx", {31'b0, tx}, 32'h1);
        bus_read(A_ST, rd);
        checkOutput("fifo discarded status", rd, 32'h4 | FEAT);

        for (int it = 0; it < 20; it++) begin
            d = $urandom_range(0, 5);
            k = $urandom_range(1, 8);
            bus_write(A_CD, d, 4'b0011, 0, w);
            exp_q.delete();
            for (int i = 0; i < k; i++) begin
                rv = $urandom;
                bus_write(A_TX, rv, 4'b1111, 0, w);
                if (i == 0) w0 = w;
                if (i < 5) exp_q.push_back(rv[7:0]);
            end
            check_stream(w0, d, "random burst");
            bus_read(A_ST, rd);
            checkOutput("random status", rd, 32'h4 | FEAT | ((k > 5) ? 32'h8 : 32'h0));
            bus_write(A_ST, 32'h8, 4'b0001, 0, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that acts as a responder on the CPU data-memory bus. It uses the same mem_read/mem_write/addr_in/data_in/byteen/data_out signalling as data memory, decodes its own 16-byte window, and buffers bytes in a small FIFO. It serialises each byte onto an 8N1 line at a programmable bit period. It sits beside dmem; the core ORs its data_out into the load path.

Parameters:
- WIDTH, 32, bus data/address width.
- BASE_ADDR, 32'h1000_0000, window base; must be 16-byte aligned.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 16'd867, reset value of CLKDIV.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  load strobe.
- mem_write  in  1  store strobe.
- addr_in  in  WIDTH  byte address.
- data_in  in  WIDTH  store data.
- byteen  in  4  byte enables (0001 sb, 0011 sh, 1111 sw).
- data_out  out  WIDTH  load data; zero when not selected.
- tx  out  1  serial line; idle high.
- irq  out  1  level interrupt, high while the FIFO is empty and the FSM is in IDLE.

Behaviour:
- Reset values: FIFO empty, CLKDIV=DEFAULT_DIV, OVERRUN=0, FSM=IDLE, tx=1, irq=1. data_out follows the combinational read rule below.
- Select: sel = (addr_in[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]). Register offset is addr_in[3:2].
- Register map:
  - 0x0 TXDATA (write-only). A write with byteen[0]=1 pushes data_in[7:0]. Reads return 0.
  - 0x4 STATUS. Bit 0 busy (FSM not IDLE), bit 1 full, bit 2 empty, bit 3 OVERRUN (sticky), other bits 0. Writing 1 to bit 3 with byteen[0]=1 clears OVERRUN.
  - 0x8 CLKDIV. Bits [15:0] are R/W, each byte written under its own byteen bit. Bits [31:16] read 0.
  - 0xC reserved. Reads 0; writes ignored.
- Read path: data_out = (mem_read && sel) ? reg : 0. It is combinational with zero-cycle latency and has no side effects.
- Writes take effect on the rising edge where mem_write && sel. A write with mem_read also high is still a write.
- Push rule: a push while full (count == FIFO_DEPTH at that edge) is dropped and sets OVERRUN. This holds even if a pop occurs on the same edge.
- Simultaneous push and pop when neither full nor empty: both occur, count unchanged.
- Bit period is CLKDIV+1 cycles. A bit counter reloads at each bit boundary. A CLKDIV write mid-frame takes effect from the next bit boundary. CLKDIV=0 gives a 1-cycle bit.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx=0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each, then STOP.
  - STOP: tx=1 for one bit period. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: a TXDATA write at edge N into an empty FIFO in IDLE gives pop at edge N+1, and tx drives 0 after edge N+1.
- Asynchronous reset mid-frame: tx returns to 1 immediately and the FIFO contents are discarded.
- tx is driven from a flop (no glitches).

Optional Feature:
MMIO_UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for one bit period, giving an 11-bit frame. STATUS bit 4 reads 1 to advertise the feature.
- Undefined: no PARITY state, 10-bit frame, STATUS bit 4 reads 0.

Decomposition:
- Package mmio_pkg holds:
  - register offset constants (UART_TXDATA_OFF=2'd0, UART_STATUS_OFF=2'd1, UART_CLKDIV_OFF=2'd2);
  - STATUS bit index constants;
  - the uart_tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
- One sub-module, sync_fifo, with parameters WIDTH=8 and DEPTH. It uses pointers plus a count and exposes push, pop, full, empty and dout (combinational head).

Test Plan:
- Reset, then read 0x4 → data_out=32'h4 (empty); tx=1; irq=1; read of 0x8 returns 867.
- Write CLKDIV=3, write TXDATA=0xA5 → tx sequence of 4-cycle bits 0,1,0,1,0,0,1,0,1,1; busy=1 throughout; irq=0 until the frame ends.
- Write 0x55, 0x0F back-to-back with CLKDIV=0 → two 10-cycle frames with no idle cycle between the first stop bit and the second start bit.
- Write 6 bytes with CLKDIV=100 → the first is popped immediately, 4 are buffered, the 6th is dropped. STATUS reads 32'hA (full|OVERRUN) with busy bit 0 also set, i.e. 32'hB. Writing 0x8 to STATUS clears bit 3.
- mem_read to addr BASE+0x20 and to dmem space → data_out=0. A TXDATA write with byteen=4'b0010 → no push.
- Assert rst_n=0 mid-DATA → tx=1 within the same cycle, FIFO empty, CLKDIV back to 867. With MMIO_UART_TX_PARITY_EN, 0x07 is sent with parity bit 1 before the stop bit.
